// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Program sequencer for the processor core. Owns the program counter, drives
// the instruction memory read address, latches the fetched word into the
// instruction register and decodes its class. ALU, memory and force-constant
// instructions are handed to the datapath as one-cycle strobes, after which
// the sequencer waits for execDone. Control-class instructions (branches,
// subroutine call/return, halt and flag skips) execute here, with a bounded
// return stack for BSA/RET.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   begin execution at startAddr (only from IDLE or HALT)
//   startAddr    in   entry point loaded into the PC on start
//   imReDat_addr out  instruction memory read address (always the PC)
//   imReDat      in   instruction memory read data (combinational)
//   instr        out  instruction register
//   aluGo        out  one-cycle ALU dispatch strobe (class 1)
//   memGo        out  one-cycle memory-reference dispatch strobe (class 4)
//   frcGo        out  one-cycle force-constant dispatch strobe (class 8)
//   execDone     in   datapath completion for the dispatched instruction
//   zFlag        in   datapath zero flag
//   vFlag        in   datapath overflow flag
//   busy         out  high in FETCH, DECODE and EXEC_WAIT
//   halted       out  high in HALT
//   stackErr     out  sticky return-stack overflow/underflow
module fetch_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  output logic [ADDR_W-1:0] imReDat_addr,
  input  logic [31:0]       imReDat,
  output logic [31:0]       instr,
  output logic              aluGo,
  output logic              memGo,
  output logic              frcGo,
  input  logic              execDone,
  input  logic              zFlag,
  input  logic              vFlag,
  output logic              busy,
  output logic              halted,
  output logic              stackErr
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0] CLS_ALU  = 4'h1;
  localparam logic [3:0] CLS_CTRL = 4'h2;
  localparam logic [3:0] CLS_MEM  = 4'h4;
  localparam logic [3:0] CLS_FRC  = 4'h8;

  localparam logic [2:0] OP_BUN = 3'd0;
  localparam logic [2:0] OP_BSA = 3'd1;
  localparam logic [2:0] OP_RET = 3'd2;
  localparam logic [2:0] OP_HLT = 3'd3;
  localparam logic [2:0] OP_SIZ = 3'd4;
  localparam logic [2:0] OP_SNZ = 3'd5;
  localparam logic [2:0] OP_SIV = 3'd6;
  localparam logic [2:0] OP_SNV = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_WAIT,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              stack_err_q, stack_err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];

  logic [3:0]        cls;
  logic [2:0]        op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc1;
  logic [ADDR_W-1:0] pc_inc2;
  logic [SP_W-1:0]   sp_dec;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic              stack_full;
  logic              stack_empty;

  assign cls         = instr_q[31:28];
  assign op          = instr_q[27:25];
  assign target      = instr_q[13 +: ADDR_W];
  // PC arithmetic wraps naturally at the ADDR_W width.
  assign pc_inc1     = pc_q + ADDR_W'(1);
  assign pc_inc2     = pc_q + ADDR_W'(2);
  assign sp_dec      = sp_q - SP_W'(1);
  assign push_idx    = sp_q[IDX_W-1:0];
  assign pop_idx     = sp_dec[IDX_W-1:0];
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // Next-state, datapath strobes and stack update. Flags are sampled during
  // DECODE; execDone only matters while waiting in EXEC_WAIT.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    stack_d     = stack_q;
    aluGo       = 1'b0;
    memGo       = 1'b0;
    frcGo       = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d        = startAddr;
          sp_d        = '0;
          stack_err_d = 1'b0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        instr_d = imReDat;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        pc_d    = pc_inc1;
        case (cls)
          CLS_ALU: begin
            aluGo   = 1'b1;
            state_d = S_EXEC_WAIT;
          end
          CLS_MEM: begin
            memGo   = 1'b1;
            state_d = S_EXEC_WAIT;
          end
          CLS_FRC: begin
            frcGo   = 1'b1;
            state_d = S_EXEC_WAIT;
          end
          CLS_CTRL: begin
            case (op)
              OP_BUN: pc_d = target;
              OP_BSA: begin
                if (stack_full) begin
                  stack_err_d = 1'b1;
                  pc_d        = pc_q;
                  state_d     = S_HALT;
                end else begin
                  stack_d[push_idx] = pc_inc1;
                  sp_d              = sp_q + SP_W'(1);
                  pc_d              = target;
                end
              end
              OP_RET: begin
                if (stack_empty) begin
                  stack_err_d = 1'b1;
                  pc_d        = pc_q;
                  state_d     = S_HALT;
                end else begin
                  pc_d = stack_q[pop_idx];
                  sp_d = sp_dec;
                end
              end
              OP_HLT: begin
                pc_d    = pc_q;
                state_d = S_HALT;
              end
              OP_SIZ: pc_d = zFlag  ? pc_inc2 : pc_inc1;
              OP_SNZ: pc_d = !zFlag ? pc_inc2 : pc_inc1;
              OP_SIV: pc_d = vFlag  ? pc_inc2 : pc_inc1;
              OP_SNV: pc_d = !vFlag ? pc_inc2 : pc_inc1;
              default: pc_d = pc_inc1;
            endcase
          end
          default: pc_d = pc_inc1;
        endcase
      end
      S_EXEC_WAIT: begin
        if (execDone) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end

  // Return-stack storage needs no reset: sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign imReDat_addr = pc_q;
  assign instr        = instr_q;
  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXEC_WAIT);
  assign halted       = (state_q == S_HALT);
  assign stackErr     = stack_err_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program sequencer for the processor core: owns the PC, drives the instruction memory read address, latches the fetched word into an instruction register and decodes its class.
- ALU, memory and constant instructions are dispatched as one-cycle strobes to the datapath; the sequencer then waits for completion.
- Control-class instructions (BUN, BSA, RET, HLT, SIZ, SNZ, SIV, SNV) execute internally, with a bounded return stack for BSA/RET.

Parameters:
- ADDR_W, 10, instruction memory address width; PC width.
- STACK_DEPTH, 4, number of return-stack entries for BSA/RET.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin execution at startAddr; honoured only in IDLE or HALT.
- startAddr  in  ADDR_W  entry point loaded into PC on start.
- imReDat_addr  out  ADDR_W  instruction memory read address; always equals PC.
- imReDat  in  32  instruction memory read data, combinational from imReDat_addr.
- instr  out  32  instruction register, feeds the datapath decode.
- aluGo  out  1  one-cycle strobe: ALU instruction dispatched (class 1).
- memGo  out  1  one-cycle strobe: memory-reference instruction dispatched (class 4).
- frcGo  out  1  one-cycle strobe: force-constant instruction dispatched (class 8).
- execDone  in  1  datapath completion for the dispatched instruction.
- zFlag  in  1  datapath zero flag.
- vFlag  in  1  datapath overflow flag.
- busy  out  1  high in FETCH, DECODE and EXEC_WAIT.
- halted  out  1  high in HALT.
- stackErr  out  1  sticky return-stack overflow or underflow; cleared by reset or start.

Behaviour:
- Reset (rst_n low at an edge): state IDLE, PC=0, instr=0, sp=0.
  - All strobes, busy, halted and stackErr go to 0.
  - Reset overrides every state, including mid-EXEC_WAIT.
- States: IDLE, FETCH, DECODE, EXEC_WAIT, HALT.
- IDLE: on start, PC<=startAddr, sp<=0, stackErr<=0, go to FETCH.
- FETCH (1 cycle): instr<=imReDat (the word at PC), go to DECODE.
- DECODE (1 cycle): class is instr[31:28]; flags are sampled in this cycle.
  - Class 1, 4, 8: assert aluGo, memGo or frcGo respectively for this cycle only; PC<=PC+1; go to EXEC_WAIT.
  - Class 2, opcode instr[27:25], target instr[22:13]; always go to FETCH unless noted.
    - BUN (0): PC<=target.
    - BSA (1): push PC+1, PC<=target. If the stack is full, set stackErr and go to HALT with PC unchanged.
    - RET (2): PC<=pop. If the stack is empty, set stackErr and go to HALT with PC unchanged.
    - HLT (3): go to HALT with PC unchanged.
    - SIZ (4): PC<=PC+2 if zFlag, else PC+1.
    - SNZ (5): PC<=PC+2 if !zFlag, else PC+1.
    - SIV (6): PC<=PC+2 if vFlag, else PC+1.
    - SNV (7): PC<=PC+2 if !vFlag, else PC+1.
  - Any other class (including all-zero words): NOP; PC<=PC+1; go to FETCH.
- EXEC_WAIT: hold all strobes low; go to FETCH at the first edge where execDone=1.
  - execDone is ignored in any other state, including the DECODE cycle that issued the strobe.
- HALT: halted=1, busy=0. On start, behave exactly as IDLE.
- start is ignored in FETCH, DECODE and EXEC_WAIT.
- PC arithmetic is modulo 2^ADDR_W: 1023+1=0, 1023+2=1, 1022+2=0. Stored return addresses wrap the same way.
- Latency: control/NOP instruction = 2 cycles. Dispatched instruction = 2 cycles plus the EXEC_WAIT cycles up to and including the execDone edge.
- Return stack: LIFO, sp from 0 to STACK_DEPTH. Push and pop never occur in the same cycle.

Test Plan:
1. Reset, start with startAddr=0, IM[0]=FRC, execDone low for 3 cycles then high.
   -> imReDat_addr=0 during FETCH; frcGo high exactly 1 cycle; PC holds at 1 with no new fetch until execDone; next FETCH reads address 1.
2. IM[4]=BSA 100, IM[100]=store, IM[101]=RET.
   -> after BSA, fetch address 100 and sp=1; after RET, fetch address 5 and sp=0.
3. IM[3]=SNZ with zFlag=0 -> next fetch address 5; repeat with zFlag=1 -> next fetch address 4. SIV with vFlag=1 at address 1023 -> next fetch address 1.
4. IM[6]=HLT -> halted=1 and busy=0 from the next cycle, stable for 20 cycles. Then start with startAddr=10 -> FETCH at 10, halted=0.
5. Five nested BSA with STACK_DEPTH=4 -> the fifth sets stackErr=1 and halted=1 with PC at the fifth BSA. Separately, RET with an empty stack -> stackErr=1, halted=1.
6. Drop rst_n for one edge while in EXEC_WAIT -> next cycle state IDLE, PC=0, busy=0, all strobes 0. A later start works normally; BUN to 1023 followed by a NOP -> next fetch address 0.
